fifo_stream_reader: RTL



---
 rtl/fifo_stream_reader_if.sv | 54 +++++
 rtl/fifo_stream_reader.sv | 103 ++++++++++
 2 files changed

// File: rtl/fifo_stream_reader_if.sv
// Bundle of the FIFO read-side and output stream signals of fifo_stream_reader.
//   master : the reader (drives fifo_rd_en and the stream outputs)
//   slave  : the FIFO plus stream sink environment
// Signals:
//   fifo_rd_en  read request to the FIFO
//   fifo_empty  FIFO empty flag
//   fifo_dout   FIFO registered read data (valid the cycle after a read)
//   m_data      stream data (buffer head)
//   m_valid     stream data valid
//   m_ready     sink ready
//   m_last      final beat of a packet
//   flush       synchronous discard of buffered and in-flight data
//   pkt_done    one-cycle pulse after a packet's last beat transfers
//   buf_count   buffer occupancy 0..3
interface fifo_stream_reader_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  fifo_rd_en;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;
  logic                  flush;
  logic                  pkt_done;
  logic [1:0]            buf_count;

  modport master (
    output fifo_rd_en,
    input  fifo_empty,
    input  fifo_dout,
    output m_data,
    output m_valid,
    input  m_ready,
    output m_last,
    input  flush,
    output pkt_done,
    output buf_count
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_empty,
    output fifo_dout,
    input  m_data,
    input  m_valid,
    output m_ready,
    input  m_last,
    output flush,
    input  pkt_done,
    input  buf_count
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// Drain engine on the read side of a synchronous FIFO. Issues read enables,
// captures the FIFO's registered read data into a 3-entry buffer and presents
// it as a valid/ready stream framed into packets of PKT_LEN beats.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-high reset
//   bus  fifo_stream_reader_if.master (FIFO read side + output stream)
// Parameters:
//   DATA_WIDTH  FIFO / stream data width
//   PKT_LEN     beats per packet (>= 1); m_last marks beat PKT_LEN-1
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int PKT_LEN    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  fifo_stream_reader_if.master    bus
);

  localparam int                BEAT_W    = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

  logic [DATA_WIDTH-1:0] mem [3];
  logic [1:0]            head;
  logic [1:0]            tail;
  logic [1:0]            occ;
  logic                  inflight;
  logic [BEAT_W-1:0]     beat_cnt;
  logic                  pkt_done_q;

  logic rd_en;
  logic push;
  logic pop;
  logic valid;
  logic last;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Read issue looks only at registered state, fifo_empty and flush, so
  // m_ready never reaches fifo_rd_en combinationally. Keeping occ+inflight
  // at most 3 is what makes the buffer overflow-free; holding it at 2 before
  // issuing leaves room for the word already on its way.
  always_comb begin
    rd_en = !rst && !bus.fifo_empty && !bus.flush &&
            (({1'b0, occ} + {2'b00, inflight}) <= 3'd2);
    valid = (occ != 2'd0) && !bus.flush;
    last  = valid && (beat_cnt == LAST_BEAT);
    push  = inflight && !bus.flush;
    pop   = valid && bus.m_ready;
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = valid;
  assign bus.m_last     = last;
  assign bus.m_data     = mem[head];
  assign bus.pkt_done   = pkt_done_q;
  assign bus.buf_count  = occ;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) mem[i] <= '0;
      head       <= 2'd0;
      tail       <= 2'd0;
      occ        <= 2'd0;
      inflight   <= 1'b0;
      beat_cnt   <= '0;
      pkt_done_q <= 1'b0;
    end else if (bus.flush) begin
      // Buffer contents are left as-is; occ=0 makes them invisible.
      head       <= 2'd0;
      tail       <= 2'd0;
      occ        <= 2'd0;
      inflight   <= 1'b0;
      beat_cnt   <= '0;
      pkt_done_q <= 1'b0;
    end else begin
      inflight   <= rd_en;
      pkt_done_q <= pop && last;
      if (push) begin
        mem[tail] <= bus.fifo_dout;
        tail      <= ptr_inc(tail);
      end
      if (pop) begin
        head     <= ptr_inc(head);
        beat_cnt <= last ? '0 : beat_cnt + BEAT_W'(1);
      end
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (occ == 2'd3)));

  a_no_read_when_empty: assert property (@(posedge clk) disable iff (rst)
    !(rd_en && bus.fifo_empty));

endmodule
